// File: rtl/fiber_frame_mux_v2.sv
// fiber_frame_mux_v2
// N-channel AXI-Stream frame multiplexer in front of the Aurora 64B66B TX FIFO.
// Whole frames are granted round-robin, each gets a one-beat header, frames
// longer than MAX_BEATS payload beats are cut (remainder drained) and counted.
//
// Handshake: a beat moves on any interface only on a rising fiber_clk edge where
// tvalid and tready are both high; a producer holds tvalid and its data stable
// until that happens, and tready may depend combinationally on the consumer's
// registered state (here s_tready follows m_tready through the load condition).
module fiber_frame_mux_v2 #(
  parameter int          N_CH      = 2,
  parameter int          MAX_BEATS = 1024,
  parameter logic [15:0] SYNC_WORD = 16'hEB90
) (
  input  logic               fiber_clk,
  input  logic               aresetn,
  input  logic               enable,
  input  logic [7:0]         wave_code,
  input  logic [64*N_CH-1:0] s_tdata,
  input  logic [N_CH-1:0]    s_tvalid,
  input  logic [N_CH-1:0]    s_tlast,
  output logic [N_CH-1:0]    s_tready,
  output logic [63:0]        m_tdata,
  output logic               m_tvalid,
  output logic [7:0]         m_tkeep,
  output logic               m_tlast,
  input  logic               m_tready,
  output logic [2:0]         cur_ch,
  output logic               busy,
  output logic [15:0]        frame_cnt,
  output logic [15:0]        trunc_cnt
);

  typedef enum logic [1:0] {IDLE, HDR, DATA, DROP} state_t;

  state_t      state;
  logic [2:0]  rr_ptr;
  logic [7:0]  wave_q;
  logic [15:0] bc;
  logic [15:0] seq_cnt [N_CH];

  logic        ld;
  logic [63:0] sel_data;
  logic        sel_valid;
  logic        sel_last;
  logic [15:0] sel_seq;
  logic        gnt_found;
  logic [2:0]  gnt_ch;
  logic        at_max;
  logic        frame_done;
  logic [63:0] hdr_word;

  // The output register can take a new beat when it is empty or being drained.
  assign ld       = ~m_tvalid | m_tready;
  assign m_tkeep  = 8'hFF;
  assign busy     = (state != IDLE);
  assign at_max   = (bc == 16'(MAX_BEATS - 1));
  assign hdr_word = {SYNC_WORD, 5'b0, cur_ch, wave_q, frame_cnt, sel_seq};

  // A data beat in DATA either carries s_tlast or hits the length limit: the
  // frame is complete from the output's point of view either way.
  assign frame_done = (state == DATA) & ld & sel_valid & (sel_last | at_max);

  // Route the granted channel's stream and sequence counter to the datapath.
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_seq   = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (cur_ch == 3'(k)) begin
        sel_data  = s_tdata[64*k +: 64];
        sel_valid = s_tvalid[k];
        sel_last  = s_tlast[k];
        sel_seq   = seq_cnt[k];
      end
    end
  end

  // Round-robin pick: first requester strictly after rr_ptr in cyclic order.
  always_comb begin
    gnt_found = 1'b0;
    gnt_ch    = '0;
    for (int i = 1; i <= N_CH; i++) begin
      for (int k = 0; k < N_CH; k++) begin
        if (!gnt_found && s_tvalid[k] && (((int'(rr_ptr) + i) % N_CH) == k)) begin
          gnt_found = 1'b1;
          gnt_ch    = 3'(k);
        end
      end
    end
  end

  // Only the granted channel is ever ready; DROP swallows beats unconditionally.
  always_comb begin
    s_tready = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (cur_ch == 3'(k)) begin
        if (state == DATA) s_tready[k] = ld;
        else if (state == DROP) s_tready[k] = 1'b1;
      end
    end
  end

  // Frame FSM, output register and all counters.
  always_ff @(posedge fiber_clk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= IDLE;
      cur_ch    <= '0;
      rr_ptr    <= 3'(N_CH - 1);
      wave_q    <= '0;
      bc        <= '0;
      m_tdata   <= '0;
      m_tvalid  <= 1'b0;
      m_tlast   <= 1'b0;
      frame_cnt <= '0;
      trunc_cnt <= '0;
      for (int k = 0; k < N_CH; k++) seq_cnt[k] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ld) begin
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
          end
          if (enable && gnt_found) begin
            cur_ch <= gnt_ch;
            wave_q <= wave_code;
            state  <= HDR;
          end
        end
        HDR: begin
          if (ld) begin
            m_tdata  <= hdr_word;
            m_tvalid <= 1'b1;
            m_tlast  <= 1'b0;
            bc       <= '0;
            state    <= DATA;
          end
        end
        DATA: begin
          if (ld) begin
            if (sel_valid) begin
              m_tdata  <= sel_data;
              m_tvalid <= 1'b1;
              bc       <= bc + 16'd1;
              if (sel_last) begin
                m_tlast <= 1'b1;
                state   <= IDLE;
              end else if (at_max) begin
                m_tlast <= 1'b1;
                state   <= DROP;
                if (trunc_cnt != 16'hFFFF) trunc_cnt <= trunc_cnt + 16'd1;
              end else begin
                m_tlast <= 1'b0;
              end
            end else begin
              m_tvalid <= 1'b0;
              m_tlast  <= 1'b0;
            end
          end
        end
        DROP: begin
          if (ld) begin
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
          end
          if (sel_valid && sel_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (frame_done) begin
        rr_ptr    <= cur_ch;
        frame_cnt <= frame_cnt + 16'd1;
        for (int k = 0; k < N_CH; k++) begin
          if (cur_ch == 3'(k)) seq_cnt[k] <= seq_cnt[k] + 16'd1;
        end
      end
    end
  end

endmodule
